banco_registradores_param: RTL
==============================

BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, 2..64; derived AW = log2(NREGS).
REQ-003 SHALL have parameter WB_EST_A, default 4'b0110: first estado value enabling writeback.
REQ-004 SHALL have parameter WB_EST_B, default 4'b0111: second estado value enabling writeback.
REQ-005 SHALL have ports: clk in 1 (single clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-006 SHALL have ports: estado in 4 (control FSM state); rs1, rs2, rd in AW (read/write indices).
REQ-007 SHALL have ports: regiwrite in 1 (write request); memtoreg in 1 (1 = memory data, 0 = ALU data).
REQ-008 SHALL have ports: writedataR in XLEN (ALU result); readdataM in XLEN (memory data).
REQ-009 SHALL have ports: readdata1R, readdata2R out XLEN (read ports).
REQ-010 SHALL have ports: dump_req in 1 (start register dump); dump_ready in 1 (sink accepts beat).
REQ-011 SHALL have ports: dump_valid out 1; dump_idx out AW; dump_data out XLEN; dump_last out 1; dump_busy out 1.

Function
REQ-012 SHALL commit a write on rising clk when regiwrite=1, estado equals WB_EST_A or WB_EST_B, and rd!=0; data = memtoreg ? readdataM : writedataR.
REQ-013 SHALL hold register 0 at zero permanently; writes to rd=0 are dropped, and reads of index 0 return 0.
REQ-014 SHALL drive readdata1R/readdata2R combinationally from the array at rs1/rs2 (zero latency).
REQ-015 SHALL implement the dump FSM with states IDLE and SCAN; reset state IDLE.
REQ-016 SHALL move IDLE->SCAN on a clk edge with dump_req=1, loading index 0; dump_req is ignored in SCAN.
REQ-017 SHALL, in SCAN, assert dump_valid=1 and dump_busy=1, with dump_idx = current index and dump_data = array[index] (combinational, reflecting writes already committed).
REQ-018 SHALL transfer a beat when dump_valid & dump_ready; the index increments on the transfer edge and holds while dump_ready=0, keeping dump_idx and dump_data stable apart from writes to that index.
REQ-019 SHALL assert dump_last when index = NREGS-1; the transfer of that beat returns the FSM to IDLE.
REQ-020 SHALL, in IDLE, drive dump_valid=0, dump_busy=0, dump_last=0, dump_idx=0, and dump_data=0.
REQ-021 SHALL make a write and a dump beat to the same index on the same edge emit the pre-write value; the new value is visible from the next cycle.
REQ-022 SHALL never block or delay register writes or reads because of the dump FSM.

Reset
REQ-023 SHALL, while rst_n=0 and independent of clk, clear all NREGS registers to 0, force the FSM to IDLE with index 0, and deassert dump_valid, dump_busy, and dump_last.
REQ-024 SHALL abort an in-progress scan on reset with no further beats; a new scan after release restarts at index 0.
REQ-025 SHALL perform no writes while rst_n=0; the first write occurs on the first qualifying edge after release.

Configuration
REQ-026 SHALL, when macro REGFILE_BYPASS_EN is defined, return the write data combinationally on a read port whose index equals a qualifying, nonzero rd in the same cycle (write-through forwarding).
REQ-027 SHALL, without REGFILE_BYPASS_EN, return the stored (old) value on read ports during a same-cycle write; the new value appears the cycle after the edge. The dump port never bypasses.

Verification
REQ-028 SHALL cover this scenario: reset, then read every rs1/rs2 index -> all 0; pulse rst_n low mid-scan at idx 5 -> dump_valid=0 immediately and FSM IDLE.
REQ-029 SHALL cover this scenario: estado=0110, regiwrite=1, memtoreg=0, rd=3, writedataR=32'hDEADBEEF -> rs1=3 reads DEADBEEF next cycle; same with estado=0010 -> register 3 unchanged.
REQ-030 SHALL cover this scenario: estado=0111, memtoreg=1, rd=0, readdataM=32'h12345678 -> register 0 reads 0.
REQ-031 SHALL cover this scenario: rd=rs2=7, writedataR=32'hA5A5A5A5 qualifying -> readdata2R=A5A5A5A5 in the same cycle with REGFILE_BYPASS_EN, old value without it.
REQ-032 SHALL cover this scenario: after writing reg k = k*16, pulse dump_req with dump_ready=1 -> 32 consecutive beats, idx 0..31, data k*16, dump_last only on idx 31, then IDLE.
REQ-033 SHALL cover this scenario: a scan with dump_ready toggling 1,0,0,1 -> no beat lost or duplicated; dump_idx stable during the stall cycles.

Source files
------------

// File: rtl/banco_registradores_param.sv
// Register file: two combinational read ports, writeback gated by the control
// FSM state, register 0 hardwired to zero, and a ready/valid dump scanner that
// walks every register in index order without disturbing normal access.
// Optional macro REGFILE_BYPASS_EN: read ports forward same-cycle write data.
module banco_registradores_param #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter logic [3:0]  WB_EST_A = 4'b0110,
   parameter logic [3:0]  WB_EST_B = 4'b0111
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [3:0]                 estado,
   input  logic [$clog2(NREGS)-1:0]   rs1,
   input  logic [$clog2(NREGS)-1:0]   rs2,
   input  logic [$clog2(NREGS)-1:0]   rd,
   input  logic                       regiwrite,
   input  logic                       memtoreg,
   input  logic [XLEN-1:0]            writedataR,
   input  logic [XLEN-1:0]            readdataM,
   output logic [XLEN-1:0]            readdata1R,
   output logic [XLEN-1:0]            readdata2R,
   input  logic                       dump_req,
   input  logic                       dump_ready,
   output logic                       dump_valid,
   output logic [$clog2(NREGS)-1:0]   dump_idx,
   output logic [XLEN-1:0]            dump_data,
   output logic                       dump_last,
   output logic                       dump_busy
);

   localparam int unsigned AW = $clog2(NREGS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;

   logic            wr_en_c;
   logic [XLEN-1:0] wr_data_c;

   // Writeback qualification and source select
   always_comb begin
      wr_en_c   = regiwrite && ((estado == WB_EST_A) || (estado == WB_EST_B)) && (rd != '0);
      wr_data_c = memtoreg ? readdataM : writedataR;
   end

   // Next array contents; register 0 is forced to zero regardless of writes
   always_comb begin
      regs_d = regs_q;
      if (wr_en_c) begin
         regs_d[rd] = wr_data_c;
      end
      regs_d[0] = '0;
   end

   // Read ports, optionally forwarding the write in flight
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      readdata1R = (wr_en_c && (rs1 == rd)) ? wr_data_c : regs_q[rs1];
      readdata2R = (wr_en_c && (rs2 == rd)) ? wr_data_c : regs_q[rs2];
`else
      readdata1R = regs_q[rs1];
      readdata2R = regs_q[rs2];
`endif
   end

   // Dump scanner next-state and beat outputs; dump data reads stored values only
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      dump_last  = 1'b0;
      dump_idx   = '0;
      dump_data  = '0;
      case (state_q)
         ST_IDLE: begin
            if (dump_req) begin
               state_d = ST_SCAN;
               idx_d   = '0;
            end
         end
         ST_SCAN: begin
            dump_valid = 1'b1;
            dump_busy  = 1'b1;
            dump_idx   = idx_q;
            dump_data  = regs_q[idx_q];
            dump_last  = (idx_q == LAST_IDX);
            if (dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State, index and array registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q  <= '{default: '0};
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         regs_q  <= regs_d;
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

endmodule
